// File: rtl/cpu_control_pkg.sv
// Shared opcode, select and control-word definitions for the multi-cycle CPU controller.
package cpu_control_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HLT  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_ALU  = 8'h03;
    localparam logic [7:0] OP_CMP  = 8'h04;
    localparam logic [7:0] OP_PUSH = 8'h05;
    localparam logic [7:0] OP_LDI  = 8'h06;
    localparam logic [7:0] OP_JMP  = 8'h07;
    localparam logic [7:0] OP_CALL = 8'h08;
    localparam logic [7:0] OP_LDX  = 8'h09;
    localparam logic [7:0] OP_STX  = 8'h0A;
    localparam logic [7:0] OP_POP  = 8'h0B;
    localparam logic [7:0] OP_RET  = 8'h0C;

    localparam logic [1:0] ADDR_PC = 2'd0;
    localparam logic [1:0] ADDR_SP = 2'd1;
    localparam logic [1:0] ADDR_X  = 2'd2;

    localparam logic [1:0] RFW_REG = 2'd0;
    localparam logic [1:0] RFW_ALU = 2'd1;
    localparam logic [1:0] RFW_MEM = 2'd2;

    localparam logic WD_REG  = 1'b0;
    localparam logic WD_PC   = 1'b1;
    localparam logic PCS_MEM = 1'b0;
    localparam logic PCS_TMP = 1'b1;

    // Where an opcode goes after S_DECODE.
    typedef enum logic [2:0] {
        CLS_NOP, CLS_HALT, CLS_EXEC, CLS_IMM, CLS_MEM, CLS_BAD
    } op_class_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] addr_sel;
        logic       wdata_sel;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       pc_src;
        logic       tmp_load;
        logic       sp_inc;
        logic       sp_dec;
        logic       rf_we;
        logic [1:0] rf_wsel;
        logic       flags_we;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic op_class_e op_class(input logic [7:0] op);
        case (op)
            OP_NOP:                          return CLS_NOP;
            OP_HLT:                          return CLS_HALT;
            OP_MOV, OP_ALU, OP_CMP, OP_PUSH: return CLS_EXEC;
            OP_LDI, OP_JMP, OP_CALL:         return CLS_IMM;
            OP_LDX, OP_STX, OP_POP, OP_RET:  return CLS_MEM;
            default:                         return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control.sv
// Multi-cycle control FSM: registered state, combinational decode of state and opcode
// into memory handshake, datapath strobes and source selects.
module cpu_control
    import cpu_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] opcode,
    input  logic       jmp_taken,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] addr_sel,
    output logic       wdata_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_src,
    output logic       tmp_load,
    output logic       sp_inc,
    output logic       sp_dec,
    output logic       rf_we,
    output logic [1:0] rf_wsel,
    output logic       flags_we,
    output logic       halted,
    output logic       illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_IMM    = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0] state_q, state_d;
    ctrl_t      c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        c       = '0;
        case (state_q)
            S_FETCH: begin
                c.mem_req  = 1'b1;
                c.addr_sel = ADDR_PC;
                if (mem_ack) begin
                    c.ir_load = 1'b1;
                    c.pc_inc  = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_class(opcode))
                    CLS_NOP:  state_d = S_FETCH;
                    CLS_HALT: state_d = S_HALT;
                    CLS_EXEC: state_d = S_EXEC;
                    CLS_IMM:  state_d = S_IMM;
                    CLS_MEM:  state_d = S_MEM;
                    default: begin
                        c.illegal = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_IMM: begin
                c.mem_req  = 1'b1;
                c.addr_sel = ADDR_PC;
                if (mem_ack) begin
                    state_d = S_FETCH;
                    case (opcode)
                        OP_LDI: begin
                            c.rf_we   = 1'b1;
                            c.rf_wsel = RFW_MEM;
                            c.pc_inc  = 1'b1;
                        end
                        OP_JMP: begin
                            c.pc_load = jmp_taken;
                            c.pc_src  = PCS_MEM;
                            c.pc_inc  = !jmp_taken;
                        end
                        OP_CALL: begin
                            c.tmp_load = 1'b1;
                            c.pc_inc   = 1'b1;
                            state_d    = S_EXEC;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_MOV: begin
                        c.rf_we   = 1'b1;
                        c.rf_wsel = RFW_REG;
                    end
                    OP_ALU: begin
                        c.rf_we    = 1'b1;
                        c.rf_wsel  = RFW_ALU;
                        c.flags_we = 1'b1;
                    end
                    OP_CMP: c.flags_we = 1'b1;
                    OP_PUSH, OP_CALL: begin
                        c.sp_dec = 1'b1;
                        state_d  = S_MEM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Request shape depends only on opcode, so it holds steady across wait states.
                c.mem_req   = 1'b1;
                c.addr_sel  = (opcode == OP_LDX || opcode == OP_STX) ? ADDR_X : ADDR_SP;
                c.mem_we    = (opcode == OP_STX || opcode == OP_PUSH || opcode == OP_CALL);
                c.wdata_sel = (opcode == OP_CALL) ? WD_PC : WD_REG;
                if (mem_ack) begin
                    state_d = S_FETCH;
                    case (opcode)
                        OP_LDX: begin
                            c.rf_we   = 1'b1;
                            c.rf_wsel = RFW_MEM;
                        end
                        OP_POP: begin
                            c.rf_we   = 1'b1;
                            c.rf_wsel = RFW_MEM;
                            c.sp_inc  = 1'b1;
                        end
                        OP_RET: begin
                            c.pc_load = 1'b1;
                            c.pc_src  = PCS_MEM;
                            c.sp_inc  = 1'b1;
                        end
                        OP_CALL: begin
                            c.pc_load = 1'b1;
                            c.pc_src  = PCS_TMP;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT:  c.halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // Gating with rst_n makes mem_req and every strobe drop the moment reset asserts.
        if (!rst_n) c = '0;
    end

    assign mem_req   = c.mem_req;
    assign mem_we    = c.mem_we;
    assign addr_sel  = c.addr_sel;
    assign wdata_sel = c.wdata_sel;
    assign ir_load   = c.ir_load;
    assign pc_inc    = c.pc_inc;
    assign pc_load   = c.pc_load;
    assign pc_src    = c.pc_src;
    assign tmp_load  = c.tmp_load;
    assign sp_inc    = c.sp_inc;
    assign sp_dec    = c.sp_dec;
    assign rf_we     = c.rf_we;
    assign rf_wsel   = c.rf_wsel;
    assign flags_we  = c.flags_we;
    assign halted    = c.halted;
    assign illegal   = c.illegal;

endmodule

// File: tb/tb_cpu_control.sv
// Cycle-table bench for cpu_control: one instance retires illegal opcodes, one halts on them.
module tb_cpu_control;
    import cpu_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] opcode = OP_NOP;
    logic       jmp_taken = 1'b0;
    logic       mem_ack = 1'b1;

    logic       req0, we0, wds0, irl0, pci0, pcl0, pcs0, tmp0, spi0, spd0, rfwe0, fwe0, hlt0, ill0;
    logic [1:0] as0, ws0;
    logic       req1, we1, wds1, irl1, pci1, pcl1, pcs1, tmp1, spi1, spd1, rfwe1, fwe1, hlt1, ill1;
    logic [1:0] as1, ws1;
    logic [17:0] act0, act1;

    always #5 clk = ~clk;

    cpu_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .jmp_taken(jmp_taken), .mem_ack(mem_ack),
        .mem_req(req0), .mem_we(we0), .addr_sel(as0), .wdata_sel(wds0), .ir_load(irl0),
        .pc_inc(pci0), .pc_load(pcl0), .pc_src(pcs0), .tmp_load(tmp0), .sp_inc(spi0),
        .sp_dec(spd0), .rf_we(rfwe0), .rf_wsel(ws0), .flags_we(fwe0), .halted(hlt0),
        .illegal(ill0)
    );

    cpu_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .jmp_taken(jmp_taken), .mem_ack(mem_ack),
        .mem_req(req1), .mem_we(we1), .addr_sel(as1), .wdata_sel(wds1), .ir_load(irl1),
        .pc_inc(pci1), .pc_load(pcl1), .pc_src(pcs1), .tmp_load(tmp1), .sp_inc(spi1),
        .sp_dec(spd1), .rf_we(rfwe1), .rf_wsel(ws1), .flags_we(fwe1), .halted(hlt1),
        .illegal(ill1)
    );

    assign act0 = {req0, we0, as0, wds0, irl0, pci0, pcl0, pcs0, tmp0, spi0, spd0,
                   rfwe0, ws0, fwe0, hlt0, ill0};
    assign act1 = {req1, we1, as1, wds1, irl1, pci1, pcl1, pcs1, tmp1, spi1, spd1,
                   rfwe1, ws1, fwe1, hlt1, ill1};

    localparam logic [17:0] NONE = 18'd0;
    localparam logic [17:0] REQ  = 18'd1 << 17;
    localparam logic [17:0] WE   = 18'd1 << 16;
    localparam logic [17:0] ASP  = 18'd1 << 14;
    localparam logic [17:0] AX   = 18'd2 << 14;
    localparam logic [17:0] WDPC = 18'd1 << 13;
    localparam logic [17:0] IRL  = 18'd1 << 12;
    localparam logic [17:0] PCI  = 18'd1 << 11;
    localparam logic [17:0] PCL  = 18'd1 << 10;
    localparam logic [17:0] PCS  = 18'd1 << 9;
    localparam logic [17:0] TMPL = 18'd1 << 8;
    localparam logic [17:0] SPI  = 18'd1 << 7;
    localparam logic [17:0] SPD  = 18'd1 << 6;
    localparam logic [17:0] RFWE = 18'd1 << 5;
    localparam logic [17:0] WALU = 18'd1 << 3;
    localparam logic [17:0] WMEM = 18'd2 << 3;
    localparam logic [17:0] FWE  = 18'd1 << 2;
    localparam logic [17:0] HLTO = 18'd1 << 1;
    localparam logic [17:0] ILL  = 18'd1;
    localparam logic [17:0] FACK = REQ | IRL | PCI;

    typedef struct {
        logic [7:0]  op;
        logic        jt;
        logic        ack;
        logic [17:0] exp0;
        logic [17:0] exp1;
        string       nm;
    } vec_t;

    vec_t        tbl[$];
    logic [17:0] sb0[$];
    logic [17:0] sb1[$];
    string       sbn[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t v(input logic [7:0] op, input logic jt, input logic ack,
                               input logic [17:0] e, input string nm);
        vec_t r;
        r.op = op; r.jt = jt; r.ack = ack; r.exp0 = e; r.exp1 = e; r.nm = nm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectations, compare on the falling edge.
    task automatic apply(input logic [7:0] op, input logic jt, input logic ack,
                         input logic [17:0] e0, input logic [17:0] e1, input string nm);
        logic [17:0] x0, x1;
        string       n;
        opcode = op; jmp_taken = jt; mem_ack = ack;
        sb0.push_back(e0); sb1.push_back(e1); sbn.push_back(nm);
        @(negedge clk);
        x0 = sb0.pop_front(); x1 = sb1.pop_front(); n = sbn.pop_front();
        chk({n, "_d0"}, act0, x0);
        chk({n, "_d1"}, act1, x1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(v(OP_NOP,  0, 1, FACK, "nop_fetch"));
        tbl.push_back(v(OP_NOP,  0, 1, NONE, "nop_dec"));
        tbl.push_back(v(OP_LDI,  0, 1, FACK, "ldi_fetch"));
        tbl.push_back(v(OP_LDI,  0, 1, NONE, "ldi_dec"));
        tbl.push_back(v(OP_LDI,  0, 0, REQ, "ldi_wait1"));
        tbl.push_back(v(OP_LDI,  0, 0, REQ, "ldi_wait2"));
        tbl.push_back(v(OP_LDI,  0, 0, REQ, "ldi_wait3"));
        tbl.push_back(v(OP_LDI,  0, 1, REQ | RFWE | WMEM | PCI, "ldi_ack"));
        tbl.push_back(v(OP_JMP,  1, 1, FACK, "jmpt_fetch"));
        tbl.push_back(v(OP_JMP,  1, 0, NONE, "jmpt_dec"));
        tbl.push_back(v(OP_JMP,  1, 1, REQ | PCL, "jmp_taken"));
        tbl.push_back(v(OP_JMP,  0, 1, FACK, "jmpn_fetch"));
        tbl.push_back(v(OP_JMP,  0, 0, NONE, "jmpn_dec"));
        tbl.push_back(v(OP_JMP,  0, 1, REQ | PCI, "jmp_not"));
        tbl.push_back(v(OP_CALL, 0, 1, FACK, "call_fetch"));
        tbl.push_back(v(OP_CALL, 0, 1, NONE, "call_dec"));
        tbl.push_back(v(OP_CALL, 0, 1, REQ | TMPL | PCI, "call_imm"));
        tbl.push_back(v(OP_CALL, 0, 1, SPD, "call_exec"));
        tbl.push_back(v(OP_CALL, 0, 1, REQ | WE | ASP | WDPC | PCL | PCS, "call_mem"));
        tbl.push_back(v(OP_MOV,  0, 1, FACK, "mov_fetch"));
        tbl.push_back(v(OP_MOV,  0, 0, NONE, "mov_dec"));
        tbl.push_back(v(OP_MOV,  0, 0, RFWE, "mov_exec"));
        tbl.push_back(v(OP_ALU,  0, 1, FACK, "alu_fetch"));
        tbl.push_back(v(OP_ALU,  0, 0, NONE, "alu_dec"));
        tbl.push_back(v(OP_ALU,  0, 0, RFWE | WALU | FWE, "alu_exec"));
        tbl.push_back(v(OP_CMP,  0, 1, FACK, "cmp_fetch"));
        tbl.push_back(v(OP_CMP,  0, 0, NONE, "cmp_dec"));
        tbl.push_back(v(OP_CMP,  0, 0, FWE, "cmp_exec"));
        tbl.push_back(v(OP_PUSH, 0, 1, FACK, "push_fetch"));
        tbl.push_back(v(OP_PUSH, 0, 0, NONE, "push_dec"));
        tbl.push_back(v(OP_PUSH, 0, 1, SPD, "push_exec"));
        tbl.push_back(v(OP_PUSH, 0, 1, REQ | WE | ASP, "push_mem"));
        tbl.push_back(v(OP_LDX,  0, 1, FACK, "ldx_fetch"));
        tbl.push_back(v(OP_LDX,  0, 0, NONE, "ldx_dec"));
        tbl.push_back(v(OP_LDX,  0, 1, REQ | AX | RFWE | WMEM, "ldx_mem"));
        tbl.push_back(v(OP_STX,  0, 1, FACK, "stx_fetch"));
        tbl.push_back(v(OP_STX,  0, 0, NONE, "stx_dec"));
        tbl.push_back(v(OP_STX,  0, 0, REQ | WE | AX, "stx_wait"));
        tbl.push_back(v(OP_STX,  0, 1, REQ | WE | AX, "stx_mem"));
        tbl.push_back(v(OP_POP,  0, 1, FACK, "pop_fetch"));
        tbl.push_back(v(OP_POP,  0, 0, NONE, "pop_dec"));
        tbl.push_back(v(OP_POP,  0, 1, REQ | ASP | RFWE | WMEM | SPI, "pop_mem"));
        tbl.push_back(v(OP_RET,  0, 1, FACK, "ret_fetch"));
        tbl.push_back(v(OP_RET,  0, 0, NONE, "ret_dec"));
        tbl.push_back(v(OP_RET,  0, 1, REQ | ASP | PCL | SPI, "ret_mem"));
        tbl.push_back(v(8'hFF,   0, 1, FACK, "ill_fetch"));
        tbl.push_back(v(8'hFF,   0, 0, ILL, "ill_dec"));
        tbl.push_back(v(OP_NOP,  0, 0, REQ, "ill_refetch"));
        tbl.push_back(v(OP_HLT,  0, 1, FACK, "hlt_fetch"));
        tbl.push_back(v(OP_HLT,  0, 1, NONE, "hlt_dec"));
        tbl.push_back(v(OP_HLT,  0, 1, HLTO, "hlt_state"));
        // The halt-on-illegal instance sits in S_HALT from the cycle after the illegal decode.
        for (int i = 47; i < tbl.size(); i++) tbl[i].exp1 = HLTO;

        // Reset held with ack asserted: everything quiet.
        @(negedge clk);
        chk("reset_d0", act0, NONE);
        chk("reset_d1", act1, NONE);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].op, tbl[i].jt, tbl[i].ack, tbl[i].exp0, tbl[i].exp1, tbl[i].nm);

        for (int i = 0; i < 20; i++)
            apply(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), HLTO, HLTO, "halt_hold");

        // Reset in the middle of a PUSH memory cycle with the ack about to arrive.
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_halt_d1", act1, NONE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(OP_PUSH, 0, 1, FACK, FACK, "rpush_fetch");
        apply(OP_PUSH, 0, 0, NONE, NONE, "rpush_dec");
        apply(OP_PUSH, 0, 0, SPD, SPD, "rpush_exec");
        opcode = OP_PUSH; mem_ack = 1'b0;
        #1;
        chk("rpush_mem", act0, REQ | WE | ASP);
        rst_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rst_drop_d0", act0, NONE);
        chk("rst_drop_d1", act1, NONE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(OP_NOP, 0, 1, FACK, FACK, "post_rst_fetch");
        apply(OP_NOP, 0, 1, NONE, NONE, "post_rst_dec");
        apply(OP_NOP, 0, 0, REQ, REQ, "post_rst_refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
